// File: rtl/servo_cmd_gen.sv
// Servo command generator: box-averages ADC samples, maps the average into the
// PWM duty window and slew-limits the duty count, updating it once per PWM frame.
module servo_cmd_gen #(
  parameter int ADC_W     = 12,
  parameter int AVG_LOG2  = 3,
  parameter int CNT_MIN   = 50,
  parameter int CNT_MAX   = 100,
  parameter int CNT_RST   = 75,
  parameter int SLEW_STEP = 2,
  parameter int PERIOD    = 1001
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             adc_ready,
  output logic [7:0]       cntout,
  output logic             frame_tick,
  output logic             update,
  output logic             at_target,
  output logic [1:0]       dbg_state
);

  // Handshake: a sample transfers on any clkin edge where adc_valid and
  // adc_ready are both high; nothing is buffered while adc_ready is low.

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_MAP  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int PROD_W = ADC_W + 8;
  localparam int FW     = $clog2(PERIOD);

  localparam logic [FW-1:0]       FRAME_LAST = FW'(PERIOD - 1);
  localparam logic [7:0]          SPAN       = 8'(CNT_MAX - CNT_MIN);
  localparam logic [7:0]          LO         = 8'(CNT_MIN);
  localparam logic [7:0]          RST_CNT    = 8'(CNT_RST);
  localparam logic [7:0]          SLEW       = 8'(SLEW_STEP);
  localparam logic [AVG_LOG2-1:0] LAST_SMP   = '1;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] smp_q, smp_d;
  logic [ADC_W-1:0]    avg_q, avg_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [7:0]          target_q, target_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          diff, step;
  logic                ready_q, ready_d;
  logic                tick_q, tick_d;
  logic                update_q, update_d;
  logic                at_target_q, at_target_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    smp_d    = smp_q;
    avg_d    = avg_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    update_d = 1'b0;
    frame_d  = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
    sum      = acc_q + ACC_W'(adc_data);
    diff     = (target_q >= cnt_q) ? target_q - cnt_q : cnt_q - target_q;
    step     = (diff > SLEW) ? SLEW : diff;

    case (state_q)
      ST_ACC: begin
        if (adc_valid && ready_q) begin
          if (smp_q == LAST_SMP) begin
            avg_d   = ADC_W'(sum >> AVG_LOG2);
            acc_d   = '0;
            smp_d   = '0;
            state_d = ST_MAP;
          end else begin
            acc_d = sum;
            smp_d = smp_q + 1'b1;
          end
        end
      end
      ST_MAP: begin
        // avg * span < 2^ADC_W * span, so the result stays below CNT_MAX.
        target_d = LO + 8'((PROD_W'(avg_q) * PROD_W'(SPAN)) >> ADC_W);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick_q) begin
          cnt_d    = (target_q >= cnt_q) ? cnt_q + step : cnt_q - step;
          update_d = 1'b1;
          state_d  = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase

    ready_d     = (state_d == ST_ACC);
    tick_d      = (frame_d == FRAME_LAST);
    at_target_d = (cnt_q == target_q);
  end

  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      smp_q       <= '0;
      avg_q       <= '0;
      frame_q     <= '0;
      target_q    <= RST_CNT;
      cnt_q       <= RST_CNT;
      ready_q     <= 1'b0;
      tick_q      <= 1'b0;
      update_q    <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      avg_q       <= avg_d;
      frame_q     <= frame_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      tick_q      <= tick_d;
      update_q    <= update_d;
      at_target_q <= at_target_d;
    end
  end

  assign adc_ready  = ready_q;
  assign cntout     = cnt_q;
  assign frame_tick = tick_q;
  assign update     = update_q;
  assign at_target  = at_target_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_servo_cmd_gen.sv
// Bench for servo_cmd_gen: randomized sample blocks checked every cycle against
// a transaction-level model of averaging, mapping and per-frame slew updates.
module tb_servo_cmd_gen;

  localparam int ADC_W = 12;
  localparam int P     = 97;
  localparam int LO    = 50;
  localparam int HI    = 100;
  localparam int RSTV  = 75;
  localparam int SLEW  = 2;

  logic             clkin;
  logic             rstn;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic             adc_ready;
  logic [7:0]       cntout;
  logic             frame_tick;
  logic             update;
  logic             at_target;
  logic [1:0]       dbg_state;

  servo_cmd_gen #(.PERIOD(P)) dut (
    .clkin(clkin), .rstn(rstn), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_ready(adc_ready), .cntout(cntout), .frame_tick(frame_tick),
    .update(update), .at_target(at_target), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int n;
  int samp_q[$];
  bit m_ready, m_tick, m_update, prev_update, waiting, last_accept;
  int m_cnt, m_target, wait_start, upd_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; model what the edge does, then compare all outputs.
  task automatic step();
    bit pre_acc, pre_tick;
    int pre_data, sum, avg, d;
    pre_acc  = adc_valid && m_ready;
    pre_tick = m_tick;
    pre_data = int'(adc_data);
    @(posedge clkin);
    #1;
    n++;
    prev_update = m_update;
    m_update = 1'b0;
    if (waiting && pre_tick && (n - 1) >= wait_start) begin
      d = m_target - m_cnt;
      if (d > SLEW) d = SLEW;
      if (d < -SLEW) d = -SLEW;
      m_cnt += d;
      m_update = 1'b1;
      waiting = 1'b0;
      upd_count++;
    end
    if (pre_acc) begin
      samp_q.push_back(pre_data);
      if (samp_q.size() == 8) begin
        sum = 0;
        foreach (samp_q[i]) sum += samp_q[i];
        avg = sum / 8;
        m_target = LO + (avg * (HI - LO)) / 4096;
        samp_q.delete();
        waiting = 1'b1;
        wait_start = n + 1;
      end
    end
    m_ready = !waiting;
    m_tick = ((n % P) == P - 1);
    last_accept = pre_acc;
    check_eq("adc_ready", adc_ready, m_ready);
    check_eq("frame_tick", frame_tick, m_tick);
    check_eq("update", update, m_update);
    check_eq("cntout", cntout, m_cnt);
    if (prev_update) check_eq("at_target", at_target, (m_cnt == m_target));
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    #3;
    rstn = 1'b1;
    #2;
    check_eq("rst_cntout", cntout, RSTV);
    check_eq("rst_ready", adc_ready, 0);
    check_eq("rst_update", update, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_at_target", at_target, 0);
    samp_q.delete();
    n = 0; m_cnt = RSTV; m_target = RSTV; waiting = 0; wait_start = 0;
    m_ready = 0; m_tick = 0; m_update = 0; prev_update = 0; last_accept = 0;
    #10;
    rstn = 1'b0;
  endtask

  // driver tasks
  task automatic send_sample(input int d, input int max_gap);
    int gap, budget;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      adc_valid = 1'b0;
      adc_data = ADC_W'($urandom_range(0, 4095));
      step();
    end
    adc_valid = 1'b1;
    adc_data = ADC_W'(d);
    budget = 0;
    do begin
      step();
      budget++;
    end while (!last_accept && budget < 4 * P);
    if (!last_accept) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic send_block(input int blk[8], input int max_gap);
    for (int i = 0; i < 8; i++) send_sample(blk[i], max_gap);
  endtask

  task automatic send_const(input int v);
    int blk[8];
    foreach (blk[i]) blk[i] = v;
    send_block(blk, 0);
  endtask

  task automatic wait_update();
    int start, budget;
    adc_valid = 1'b0;
    start = upd_count;
    budget = 0;
    while (upd_count == start && budget < 3 * P) begin
      step();
      budget++;
    end
    check_eq("update_seen", update, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk[8];
    int k;
    rstn = 1'b1;
    adc_valid = 1'b0;
    adc_data = '0;
    upd_count = 0;
    @(posedge clkin);
    #1;
    do_reset();
    step();
    check_eq("post_rst_ready", adc_ready, 1);
    check_eq("post_rst_at_target", at_target, 1);

    // centre sample -> target 75, update with no movement
    send_const(2048);
    wait_update();
    check_eq("centre_cnt", cntout, 75);
    step();
    check_eq("centre_at_target", at_target, 1);

    // full scale, valid held continuously across blocks
    for (int i = 0; i < 12; i++) send_const(4095);
    wait_update();
    check_eq("full_cnt", cntout, 99);
    step();
    check_eq("full_at_target", at_target, 1);

    // zero -> down to 50 with a final 1-count step
    for (int i = 0; i < 25; i++) send_const(0);
    wait_update();
    check_eq("zero_cnt", cntout, 50);

    // small odd samples: avg truncates to 4, target stays 50
    for (int i = 0; i < 8; i++) blk[i] = i + 1;
    send_block(blk, 0);
    wait_update();
    check_eq("odd_cnt", cntout, 50);
    step();
    check_eq("odd_at_target", at_target, 1);

    // random blocks with random gaps
    for (int b = 0; b < 6; b++) begin
      foreach (blk[i]) blk[i] = $urandom_range(0, 4095);
      send_block(blk, 3);
    end
    wait_update();

    // return to 50 then climb to exactly 90
    k = 0;
    while (m_cnt != 50 && k < 40) begin
      send_const(0);
      wait_update();
      k++;
    end
    k = 0;
    while (m_cnt != 90 && k < 40) begin
      send_const(4095);
      wait_update();
      k++;
    end
    check_eq("climb_cnt", cntout, 90);

    // reset in the middle of a partial accumulation
    for (int i = 0; i < 5; i++) send_sample(4095, 0);
    do_reset();
    for (int i = 0; i < 3; i++) send_sample(4095, 0);
    adc_valid = 1'b0;
    repeat (2 * P) step();
    check_eq("partial_no_move", cntout, 75);
    for (int i = 0; i < 5; i++) send_sample(4095, 0);
    wait_update();
    check_eq("fresh_cnt", cntout, 77);
    step();
    check_eq("fresh_at_target", at_target, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
